// File: rtl/mem_init_engine_if.sv
// Bus between the power-on memory initialiser and its ROM / SDRAM / reset-tree neighbours.
// The engine drives the master side; the surrounding top level takes the slave side.
interface mem_init_engine_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned SW = 16,
    parameter int unsigned DW = 8
);
    logic          ready;
    logic          start;
    logic [SW-1:0] srcA;
    logic [DW-1:0] srcQ;
    logic [AW-1:0] memA;
    logic [DW-1:0] memD;
    logic          memWr;
    logic          busy;
    logic          done;

    modport master (
        input  ready, start, srcQ,
        output srcA, memA, memD, memWr, busy, done
    );

    modport slave (
        output ready, start, srcQ,
        input  srcA, memA, memD, memWr, busy, done
    );
endinterface

// File: rtl/mem_init_engine.sv
// Power-on memory initialiser: copies COPYLEN bytes of ROM into SDRAM, then fills the remaining
// destination space with FILL. Stalls on !ready and can be re-run with start once done.
module mem_init_engine #(
    parameter int unsigned   AW      = 19,
    parameter int unsigned   SW      = 16,
    parameter int unsigned   DW      = 8,
    parameter int unsigned   COPYLEN = 65536,
    parameter logic [DW-1:0] FILL    = 8'h00,
    parameter int unsigned   RDLAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    mem_init_engine_if.master bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    // One extra bit so COPYLEN = 2^AW (no fill phase) is representable.
    localparam logic [AW:0] CopyEnd = (AW+1)'(COPYLEN);
    localparam logic [2:0]  LatLast = 3'(RDLAT - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] mema_q, mema_d;
    logic [SW-1:0] srca_q, srca_d;
    logic [DW-1:0] memd_q, memd_d;
    logic          memwr_q, memwr_d;
    logic [2:0]    lat_q, lat_d;

    logic [AW-1:0] mema_inc;
    logic          next_copy;

    assign mema_inc  = mema_q + 1'b1;
    assign next_copy = {1'b0, mema_inc} < CopyEnd;

    always_comb begin
        state_d = state_q;
        mema_d  = mema_q;
        srca_d  = srca_q;
        memd_d  = memd_q;
        memwr_d = memwr_q;
        lat_d   = lat_q;
        if (ce) begin
            case (state_q)
                StIdle: begin
                    if (bus.ready) begin
                        state_d = StFetch;
                        mema_d  = '0;
                        srca_d  = '0;
                        lat_d   = '0;
                    end
                end
                StFetch: begin
                    if (bus.ready) begin
                        if (lat_q == LatLast) begin
                            memd_d  = bus.srcQ;
                            memwr_d = 1'b1;
                            lat_d   = '0;
                            state_d = StWrite;
                        end else begin
                            lat_d = lat_q + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    // A write tick cut short by !ready is re-issued as a full tick.
                    if (!bus.ready) begin
                        memwr_d = 1'b0;
                    end else if (!memwr_q) begin
                        memwr_d = 1'b1;
                    end else begin
                        memwr_d = 1'b0;
                        state_d = StGap;
                    end
                end
                StGap: begin
                    if (bus.ready) begin
                        if (&mema_q) begin
                            state_d = StDone;
                        end else begin
                            mema_d = mema_inc;
                            if (next_copy) begin
                                srca_d  = mema_inc[SW-1:0];
                                state_d = StFetch;
                            end else begin
                                memd_d  = FILL;
                                memwr_d = 1'b1;
                                state_d = StWrite;
                            end
                        end
                    end
                end
                StDone: begin
                    if (bus.start) begin
                        state_d = StIdle;
                        mema_d  = '0;
                        srca_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            mema_q  <= '0;
            srca_q  <= '0;
            memd_q  <= '0;
            memwr_q <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            mema_q  <= mema_d;
            srca_q  <= srca_d;
            memd_q  <= memd_d;
            memwr_q <= memwr_d;
            lat_q   <= lat_d;
        end
    end

    assign bus.srcA  = srca_q;
    assign bus.memA  = mema_q;
    assign bus.memD  = memd_q;
    assign bus.memWr = memwr_q;
    assign bus.busy  = (state_q == StFetch) || (state_q == StWrite) || (state_q == StGap);
    assign bus.done  = (state_q == StDone);

endmodule
